shift_pair_arbiter: RTL

Controller and two-way arbiter for the serial-in shift-register pair (serial input `D`, parallel outputs `X` and `Y`). Two requesters each hand over a `WIDTH`-bit word through a request/grant handshake. The block picks one requester round-robin and serializes its word MSB-first onto the shifter's `D` input over `WIDTH` shift cycles. It then captures the shifter's `X`/`Y` outputs and returns them with a one-cycle `Done` pulse tagged with the owner.

---
 rtl/shift_pair_arbiter_if.sv | 33 +++
 rtl/shift_pair_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/shift_pair_arbiter_if.sv
// Purpose: bundles the requester handshake and shifter-side signals of shift_pair_arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold Req/Data until their one-cycle Gnt pulse.
// Ports: ReqA/DataA, ReqB/DataB, GntA/GntB (requester side); D/ShEn/X/Y (shifter side);
//        ResX/ResY/Done/Owner (result side). slave = arbiter view, master = environment view.
interface shift_pair_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             ReqA;
   logic [WIDTH-1:0] DataA;
   logic             ReqB;
   logic [WIDTH-1:0] DataB;
   logic             GntA;
   logic             GntB;
   logic             D;
   logic             ShEn;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] ResX;
   logic [WIDTH-1:0] ResY;
   logic             Done;
   logic             Owner;

   modport slave (
      input  ReqA, DataA, ReqB, DataB, X, Y,
      output GntA, GntB, D, ShEn, ResX, ResY, Done, Owner
   );

   modport master (
      output ReqA, DataA, ReqB, DataB, X, Y,
      input  GntA, GntB, D, ShEn, ResX, ResY, Done, Owner
   );
endinterface

// File: rtl/shift_pair_arbiter.sv
// Purpose: round-robin arbiter that serializes a requester word MSB-first into a shifter pair and captures X/Y.
// Latency: grant 1 edge after request in IDLE; Done in cycle WIDTH+1 after grant; WIDTH+3 cycles per transaction.
// Backpressure: requests are sampled only in IDLE; a requester must drop Req while its Gnt is high.
// Ports: Clk, Rst_n (sync, active-low); bus (slave modport): ReqA/DataA, ReqB/DataB in, GntA/GntB out,
//        D/ShEn out to shifter, X/Y in from shifter, ResX/ResY/Done/Owner out.
module shift_pair_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   shift_pair_arbiter_if.slave  bus
);
   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] sbuf, sbuf_nxt;    // MSB is always the bit currently on D
   logic             last_b, last_b_nxt; // 1 = B owned the most recent grant
   logic             win_b, win_b_nxt;   // owner of the transaction in flight
   logic             pick_b;

   logic             gnt_a_nxt, gnt_b_nxt, d_nxt, shen_nxt, done_nxt;
   logic             gnt_a_q, gnt_b_q, d_q, shen_q, done_q;
   logic [WIDTH-1:0] res_x_q, res_y_q;
   logic             owner_q;

   // Lone requester wins; on a tie the one that did not own the last grant wins.
   assign pick_b = bus.ReqB & (~bus.ReqA | ~last_b);

   // State register
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sbuf   <= '0;
         last_b <= 1'b1;
         win_b  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         sbuf   <= sbuf_nxt;
         last_b <= last_b_nxt;
         win_b  <= win_b_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sbuf_nxt   = sbuf;
      last_b_nxt = last_b;
      win_b_nxt  = win_b;
      case (state)
         IDLE: begin
            if (bus.ReqA || bus.ReqB) begin
               win_b_nxt  = pick_b;
               last_b_nxt = pick_b;
               sbuf_nxt   = pick_b ? bus.DataB : bus.DataA;
               cnt_nxt    = '0;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            sbuf_nxt = sbuf << 1;
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = CAPTURE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         CAPTURE: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: computes the values the output registers take at the next edge,
   // so every output pin comes straight from a flop.
   always_comb begin
      gnt_a_nxt = 1'b0;
      gnt_b_nxt = 1'b0;
      if (state == IDLE && state_nxt == SHIFT) begin
         gnt_a_nxt = ~win_b_nxt;
         gnt_b_nxt = win_b_nxt;
      end
      shen_nxt = (state_nxt == SHIFT);
      d_nxt    = shen_nxt & sbuf_nxt[WIDTH-1];
      done_nxt = (state_nxt == DONE);
   end

   // Output registers
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         d_q     <= 1'b0;
         shen_q  <= 1'b0;
         done_q  <= 1'b0;
         res_x_q <= '0;
         res_y_q <= '0;
         owner_q <= 1'b0;
      end else begin
         gnt_a_q <= gnt_a_nxt;
         gnt_b_q <= gnt_b_nxt;
         d_q     <= d_nxt;
         shen_q  <= shen_nxt;
         done_q  <= done_nxt;
         // Shifter has had the CAPTURE cycle to settle; results hold until the next capture.
         if (state == CAPTURE) begin
            res_x_q <= bus.X;
            res_y_q <= bus.Y;
            owner_q <= win_b;
         end
      end
   end

   assign bus.GntA  = gnt_a_q;
   assign bus.GntB  = gnt_b_q;
   assign bus.D     = d_q;
   assign bus.ShEn  = shen_q;
   assign bus.Done  = done_q;
   assign bus.ResX  = res_x_q;
   assign bus.ResY  = res_y_q;
   assign bus.Owner = owner_q;
endmodule
